// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART TX serializer between NUM_REQ requesters. Whole frames of
//   1..MAX_BYTES bytes are arbitrated round-robin. The granted frame is latched
//   and then fed out one byte at a time. Each byte gets a one-cycle
//   tx_data_valid pulse. After that pulse the block waits for tx_busy to rise
//   and then fall before it sends the next byte.
//
// Ports
//   clk, rst_n     clock; asynchronous active-low reset
//   req_valid      per-requester frame request, held until req_ack
//   req_data       flattened frame words; requester i owns slice i, byte 0 = LSB
//   req_len        flattened byte counts (LEN_W bits each)
//   req_ack        one-cycle pulse to the winner once its frame is latched
//   tx_busy        UART TX busy (already synchronous to clk)
//   tx_data_valid  one-cycle start pulse to UART TX
//   tx_p_data      byte presented to UART TX (0 while idle)
//   sched_busy     high from grant until the frame finishes or aborts
//   cur_grant      one-hot owner of the current frame, 0 when idle
//   err_timeout    one-cycle pulse when tx_busy fails to rise in time
module uart_tx_scheduler #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 2,
  parameter int LEN_W     = 2,
  parameter int BUSY_TO   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*MAX_BYTES*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*LEN_W-1:0]          req_len,
  output logic [NUM_REQ-1:0]                req_ack,
  input  logic                              tx_busy,
  output logic                              tx_data_valid,
  output logic [DATA_W-1:0]                 tx_p_data,
  output logic                              sched_busy,
  output logic [NUM_REQ-1:0]                cur_grant,
  output logic                              err_timeout
);

  localparam int WORD_W = MAX_BYTES * DATA_W;
  localparam int PTR_W  = (NUM_REQ > 1)   ? $clog2(NUM_REQ)   : 1;
  localparam int IDX_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int CNT_W  = (BUSY_TO > 1)   ? $clog2(BUSY_TO)   : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Unpacked views of the flattened request buses and of the latched frame.
  logic [WORD_W-1:0]   req_word [NUM_REQ];
  logic [LEN_W-1:0]    req_len_arr [NUM_REQ];
  logic [DATA_W-1:0]   frame_byte [MAX_BYTES];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_word[gi]    = req_data[gi*WORD_W +: WORD_W];
    assign req_len_arr[gi] = req_len[gi*LEN_W +: LEN_W];
  end

  for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_byte
    assign frame_byte[gi] = word_q[gi*DATA_W +: DATA_W];
  end

  // Round-robin search. It starts one past the last winner, so the most
  // recently served requester is checked last.
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [LEN_W-1:0] win_len;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req_valid[PTR_W'((int'(ptr_q) + k) % NUM_REQ)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    win_len = req_len_arr[win_idx];
  end

  // Next-state logic and the strobe outputs.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    word_d        = word_q;
    len_d         = len_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    tx_data_valid = 1'b0;
    err_timeout   = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (win_found && !tx_busy) begin
          state_d = S_LOAD;
          ptr_d   = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
          word_d  = req_word[win_idx];
          // Oversized lengths are clamped here, so the send loop never runs past the buffer.
          len_d   = (win_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : win_len;
        end
      end
      S_LOAD: begin
        state_d = (len_q == '0) ? S_IDLE : S_SEND;
      end
      S_SEND: begin
        tx_data_valid = 1'b1;
        cnt_d         = '0;
        state_d       = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tx_busy) begin
          state_d = S_WAIT_LO;
        end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
          // The TX never started. Drop the rest of this frame and keep the pointer so fairness holds.
          err_timeout = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if ((LEN_W'(idx_q) + LEN_W'(1)) < len_q) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SEND;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      grant_q <= '0;
      word_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      word_q  <= word_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // The outputs are decoded from registered state. An asynchronous reset therefore clears them at once.
  assign sched_busy = (state_q != S_IDLE);
  assign cur_grant  = sched_busy ? grant_q : '0;
  assign req_ack    = (state_q == S_LOAD) ? grant_q : '0;
  assign tx_p_data  = (state_q == S_SEND || state_q == S_WAIT_HI || state_q == S_WAIT_LO)
                      ? frame_byte[idx_q] : '0;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler. Stimulus pushes the expected acks, bytes and
// timeouts into queues. A monitor pops entries from these queues and compares
// them whenever the DUT pulses an output.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_len;
  logic [1:0]  req_ack;
  logic        tx_busy;
  logic        tx_data_valid;
  logic [7:0]  tx_p_data;
  logic        sched_busy;
  logic [1:0]  cur_grant;
  logic        err_timeout;

  // UART TX model: busy rises 2 cycles after a pulse and stays high for 10 cycles.
  logic model_en;
  logic model_busy;
  logic force_en;
  logic force_val;
  int   dly;
  int   hold;

  assign tx_busy = force_en ? force_val : model_busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_ack[$];
  logic [9:0] exp_tx[$];
  bit         exp_err[$];

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ(2), .DATA_W(8), .MAX_BYTES(2), .LEN_W(2), .BUSY_TO(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_len(req_len),
    .req_ack(req_ack),
    .tx_busy(tx_busy),
    .tx_data_valid(tx_data_valid),
    .tx_p_data(tx_p_data),
    .sched_busy(sched_busy),
    .cur_grant(cur_grant),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ack"}, req_ack, 0);
    chk({tag, "_tx_data_valid"}, tx_data_valid, 0);
    chk({tag, "_tx_p_data"}, tx_p_data, 0);
    chk({tag, "_sched_busy"}, sched_busy, 0);
    chk({tag, "_cur_grant"}, cur_grant, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  task automatic set_req(input int r, input logic [15:0] data, input logic [1:0] len);
    req_data[r*16 +: 16] = data;
    req_len[r*2 +: 2]    = len;
    req_valid[r]         = 1'b1;
  endtask

  task automatic wait_ack(input int r, input bit drop);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ack[r]) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("ack%0d_seen", r), 32'(seen), 1);
    if (drop) req_valid[r] = 1'b0;
  endtask

  task automatic wait_dv();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_data_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("dv_seen", 32'(seen), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!sched_busy) break;
    end
    chk("idle_reached", sched_busy, 0);
  endtask

  // TX model
  initial begin
    model_busy = 1'b0;
    dly        = 0;
    hold       = 0;
    forever begin
      @(negedge clk);
      if (!model_en) begin
        model_busy = 1'b0;
        dly        = 0;
        hold       = 0;
      end else begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) model_busy = 1'b0;
        end else if (dly > 0) begin
          dly--;
          if (dly == 0) begin
            model_busy = 1'b1;
            hold       = 10;
          end
        end
        if (tx_data_valid) dly = 2;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (req_ack != 2'b00) begin
          $display("ack   req_ack=%b t=%0t", req_ack, $time);
          if (exp_ack.size() == 0) chk("unexpected_ack", req_ack, 0);
          else chk("ack_owner", req_ack, exp_ack.pop_front());
        end
        if (tx_data_valid) begin
          $display("byte  grant=%b data=0x%02h t=%0t", cur_grant, tx_p_data, $time);
          if (exp_tx.size() == 0) chk("unexpected_tx", {cur_grant, tx_p_data}, 0);
          else chk("tx_grant_byte", {cur_grant, tx_p_data}, exp_tx.pop_front());
        end
        if (err_timeout) begin
          $display("err   timeout t=%0t", $time);
          if (exp_err.size() == 0) chk("unexpected_err", err_timeout, 0);
          else chk("err_pulse", err_timeout, exp_err.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_len   = '0;
    model_en  = 1'b1;
    force_en  = 1'b0;
    force_val = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // 1: single 2-byte frame; check ack and first-pulse latency
    exp_ack.push_back(2'b01);
    exp_tx.push_back({2'b01, 8'hEF});
    exp_tx.push_back({2'b01, 8'hBE});
    set_req(0, 16'hBEEF, 2'd2);
    @(negedge clk);
    chk("t1_ack_latency", req_ack, 2'b01);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_dv_latency", tx_data_valid, 1);
    chk("t1_sched_busy", sched_busy, 1);
    wait_idle();
    chk("t1_grant_cleared", cur_grant, 0);

    // 2: after reset, both held: grants 0,1,0,1
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ack.push_back(2'b01); exp_tx.push_back({2'b01, 8'h11});
    exp_ack.push_back(2'b10); exp_tx.push_back({2'b10, 8'h22});
    exp_ack.push_back(2'b01); exp_tx.push_back({2'b01, 8'h11});
    exp_ack.push_back(2'b10); exp_tx.push_back({2'b10, 8'h22});
    set_req(0, 16'h0011, 2'd1);
    set_req(1, 16'h0022, 2'd1);
    wait_ack(0, 1'b0);
    wait_ack(1, 1'b0);
    wait_ack(0, 1'b0);
    wait_ack(1, 1'b0);
    req_valid = '0;
    wait_idle();

    // 3: tx_busy stuck low -> timeout 16 cycles after the pulse, then a normal frame
    model_en  = 1'b0;
    force_en  = 1'b1;
    force_val = 1'b0;
    exp_ack.push_back(2'b01);
    exp_tx.push_back({2'b01, 8'h33});
    exp_err.push_back(1'b1);
    set_req(0, 16'h0033, 2'd1);
    wait_ack(0, 1'b1);
    wait_dv();
    repeat (15) @(negedge clk);
    chk("t3_err_not_early", err_timeout, 0);
    @(negedge clk);
    chk("t3_err_at_16", err_timeout, 1);
    @(negedge clk);
    chk("t3_idle_after_timeout", sched_busy, 0);
    force_en = 1'b0;
    model_en = 1'b1;
    exp_ack.push_back(2'b10);
    exp_tx.push_back({2'b10, 8'h44});
    exp_tx.push_back({2'b10, 8'h55});
    set_req(1, 16'h5544, 2'd2);
    wait_ack(1, 1'b1);
    wait_idle();

    // 4: len=0 -> ack only; len=3 -> clamped to 2 bytes
    exp_ack.push_back(2'b01);
    set_req(0, 16'hAAAA, 2'd0);
    wait_ack(0, 1'b1);
    @(negedge clk);
    chk("t4_len0_idle", sched_busy, 0);
    repeat (3) @(negedge clk);
    exp_ack.push_back(2'b10);
    exp_tx.push_back({2'b10, 8'h66});
    exp_tx.push_back({2'b10, 8'h77});
    set_req(1, 16'h7766, 2'd3);
    wait_ack(1, 1'b1);
    wait_idle();
    repeat (5) @(negedge clk);

    // 5: tx_busy high in IDLE blocks the grant; ack the cycle after it falls
    force_en  = 1'b1;
    force_val = 1'b1;
    @(negedge clk);
    exp_ack.push_back(2'b10);
    exp_tx.push_back({2'b10, 8'h88});
    set_req(1, 16'h0088, 2'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_ack_while_busy", req_ack, 0);
    end
    force_en = 1'b0;
    @(negedge clk);
    chk("t5_ack_after_busy_fall", req_ack, 2'b10);
    req_valid[1] = 1'b0;
    wait_idle();

    // 6: reset mid-frame: outputs clear at once, 0xBE never sent, req0 wins first
    exp_ack.push_back(2'b01);
    exp_tx.push_back({2'b01, 8'hEF});
    set_req(0, 16'hBEEF, 2'd2);
    wait_ack(0, 1'b1);
    wait_dv();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("t6_async_reset");
    model_en = 1'b0;
    repeat (3) @(negedge clk);
    model_en = 1'b1;
    rst_n    = 1'b1;
    exp_ack.push_back(2'b01); exp_tx.push_back({2'b01, 8'h34});
    exp_ack.push_back(2'b10); exp_tx.push_back({2'b10, 8'h56});
    set_req(0, 16'h0034, 2'd1);
    set_req(1, 16'h0056, 2'd1);
    wait_ack(0, 1'b1);
    wait_ack(1, 1'b1);
    wait_idle();
    repeat (5) @(negedge clk);

    chk("ack_queue_drained", exp_ack.size(), 0);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("err_queue_drained", exp_err.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
